// File: rtl/fifo_watermark_pkg.sv
// Shared widths and read-mode constants for the watermark FIFO family.
package fifo_watermark_pkg;

  localparam int unsigned FIFO_MODE_REG  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // LEVEL needs one extra bit to represent a completely full FIFO.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/fifo_watermark_mem.sv
// Dual-port distributed RAM: synchronous write, asynchronous read, no reset.
module fifo_watermark_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_watermark.sv
// Synchronous FIFO with occupancy, almost-full/empty watermarks, sticky
// overflow/underflow flags and selectable registered or FWFT read.
module fifo_watermark
  import fifo_watermark_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned AFULL_LEVEL  = 2**FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_LEVEL = 1,
  parameter int unsigned FWFT         = FIFO_MODE_REG
) (
  input  logic                                 CLK,
  input  logic                                 nCLR,
  input  logic                                 nWE,
  input  logic [DATA_WIDTH-1:0]                DIN,
  output logic                                 FULL,
  output logic                                 AFULL,
  input  logic                                 nRE,
  output logic [DATA_WIDTH-1:0]                DOUT,
  output logic                                 EMPTY,
  output logic                                 AEMPTY,
  output logic [lvl_width(FIFO_DEPTH)-1:0]     LEVEL,
  output logic                                 OVERFLOW,
  output logic                                 UNDERFLOW,
  input  logic                                 ERR_CLR
);

  localparam int unsigned LW      = lvl_width(FIFO_DEPTH);
  localparam int unsigned ENTRIES = 2**FIFO_DEPTH;
  localparam logic        AFULL_RST = (AFULL_LEVEL == 0);

  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  // A pop frees the slot a same-cycle push needs, so pushes at full still land.
  assign pop_ok  = !nRE && !empty_q;
  assign push_ok = !nWE && (!full_q || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + FIFO_DEPTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + FIFO_DEPTH'(1);
    end

    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Clear first so a same-cycle error event takes priority.
    if (ERR_CLR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!nWE && !push_ok) begin
      ovf_d = 1'b1;
    end
    if (!nRE && !pop_ok) begin
      unf_d = 1'b1;
    end

    full_d   = (32'(level_d) == ENTRIES);
    empty_d  = (level_d == '0);
    afull_d  = (32'(level_d) >= AFULL_LEVEL);
    aempty_d = (32'(level_d) <= AEMPTY_LEVEL);
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= AFULL_RST;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_watermark_mem #(
    .ADDR_W (FIFO_DEPTH),
    .DATA_W (DATA_WIDTH)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (DIN),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign DOUT = empty_q ? '0 : rd_data;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (pop_ok) begin
          dout_d = rd_data;
        end
      end

      always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign DOUT = dout_q;
    end
  endgenerate

  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign LEVEL     = level_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: doc/fifo_watermark.md
Name: fifo_watermark

Overview:
Parametrised synchronous FIFO that is the next generation of the team's basic FiFo. It adds occupancy reporting, programmable almost-full and almost-empty watermarks, and sticky overflow/underflow error flags. It also has a selectable read mode: registered output or first-word-fall-through (FWFT). It sits between producer/consumer pipeline stages inside DUTs on the single system clock.

Parameters:
FIFO_DEPTH, 4, log2 of entry count; the FIFO holds 2**FIFO_DEPTH entries; minimum 1.
DATA_WIDTH, 32, payload width in bits.
AFULL_LEVEL, 2**FIFO_DEPTH-1, AFULL asserts when LEVEL >= this value; legal range 1..2**FIFO_DEPTH.
AEMPTY_LEVEL, 1, AEMPTY asserts when LEVEL <= this value; legal range 0..2**FIFO_DEPTH-1.
FWFT, 0, 0 = registered read (DOUT valid one cycle after pop); 1 = head word visible on DOUT whenever not EMPTY.

Ports:
CLK  input  1  system clock; all logic on rising edge.
nCLR  input  1  asynchronous active-low reset.
nWE  input  1  active-low push request.
DIN  input  DATA_WIDTH  push data.
FULL  output  1  FIFO holds 2**FIFO_DEPTH entries.
AFULL  output  1  LEVEL >= AFULL_LEVEL.
nRE  input  1  active-low pop request.
DOUT  output  DATA_WIDTH  read data.
EMPTY  output  1  FIFO holds 0 entries.
AEMPTY  output  1  LEVEL <= AEMPTY_LEVEL.
LEVEL  output  FIFO_DEPTH+1  current entry count, 0..2**FIFO_DEPTH.
OVERFLOW  output  1  sticky: a push was dropped.
UNDERFLOW  output  1  sticky: a pop was ignored.
ERR_CLR  input  1  active-high synchronous clear of OVERFLOW/UNDERFLOW.

Behaviour:
- Reset (nCLR low, asynchronous): pointers=0, LEVEL=0, EMPTY=1, FULL=0, AEMPTY=1, AFULL=(AFULL_LEVEL==0 ? 1 : 0) (0 for legal values), OVERFLOW=0, UNDERFLOW=0, DOUT=0. Reset mid-operation discards all contents; the storage array itself is not cleared.
- Storage: dual-port distributed RAM with 2**FIFO_DEPTH entries, synchronous write and asynchronous read. Pointers are FIFO_DEPTH bits and wrap naturally from 2**FIFO_DEPTH-1 to 0.
- Accept rules:
  - push_ok = !nWE && (!FULL || pop_ok)
  - pop_ok = !nRE && !EMPTY
- Write: on push_ok, mem[wr_ptr] <= DIN and wr_ptr increments.
- Read: on pop_ok, rd_ptr increments.
- LEVEL: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Flags: FULL, EMPTY, AFULL and AEMPTY are registered. Each is computed from the next LEVEL value, so it is consistent with LEVEL in the same cycle.
- Simultaneous push+pop when full: both accepted; FULL stays 1; LEVEL unchanged.
- Simultaneous push+pop when empty: pop rejected (UNDERFLOW set), push accepted; LEVEL becomes 1.
- Push while full with no pop: data dropped, OVERFLOW <= 1.
- Pop while empty: UNDERFLOW <= 1; DOUT unchanged.
- ERR_CLR: clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- FWFT=0: on pop_ok, DOUT <= mem[rd_ptr], registered, so the data is valid in the cycle after nRE is sampled low. DOUT holds its value otherwise.
- FWFT=1: DOUT = mem[rd_ptr] combinationally, qualified by !EMPTY. It is 0 when EMPTY. The first word appears in the cycle after the push that made the FIFO non-empty. A pop advances to the next word.
- Latency: push to EMPTY deassertion is 1 cycle. Push to pop-able is 1 cycle.

Decomposition:
- Package fifo_watermark_pkg: the level/pointer width function (FIFO_DEPTH+1) and the read-mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1.
- One sub-module: fifo_watermark_mem, the dual-port distributed RAM (synchronous write, asynchronous read, parametrised depth/width).
- Pointer, level, flag and error logic stay in the top module.

Test Plan:
- Setup for all scenarios: FIFO_DEPTH=2 (4 entries), DATA_WIDTH=32, AFULL_LEVEL=3, AEMPTY_LEVEL=1, FWFT=0.
- Reset state: reset, then idle -> EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, LEVEL=0, OVERFLOW=0, UNDERFLOW=0, DOUT=0.
- Fill and overflow: push 1..5 on 5 consecutive cycles -> LEVEL goes 1,2,3,4,4; AEMPTY drops when LEVEL=2; AFULL rises when LEVEL=3; FULL when LEVEL=4; 5 dropped, OVERFLOW=1.
- Drain and underflow: pop 5 times from full -> DOUT 1,2,3,4, each one cycle after its pop; 5th pop sets UNDERFLOW=1 with DOUT held at 4; EMPTY=1. Then ERR_CLR pulse -> both flags clear next cycle.
- Full simultaneous push/pop: at full with contents 1..4, push 9 together with a pop -> LEVEL stays 4, FULL stays 1, DOUT=1. Subsequent drain yields 2,3,4,9 (checks wrap-around).
- Empty simultaneous push/pop: at empty, push 7 together with a pop -> UNDERFLOW=1, LEVEL=1. Next pop returns 7.
- FWFT=1 variant: push 0xA then 0xB -> DOUT=0xA in the cycle after the first push, with no pop yet. Pop -> DOUT=0xB next cycle. Pop again -> EMPTY=1, DOUT=0.
